// File: rtl/rtt_probe_gen.sv
// rtt_probe_gen: emits bursts of 9-word timestamped RTT probe packets
module rtt_probe_gen #(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic                  out_wr,
  input  logic                  out_rdy,
  input  logic                  start,
  input  logic                  stop,
  input  logic [31:0]           num_probes,
  input  logic [31:0]           gap_cycles,
  input  logic [15:0]           dst_port,
  output logic                  busy,
  output logic [31:0]           probes_sent
);
  localparam logic [1:0] IDLE = 2'd0, HDR = 2'd1, PAYLOAD = 2'd2, GAP = 2'd3;
  logic [1:0]  state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [31:0] sent_q, sent_d, num_q, num_d, gap_q, gap_d, gcnt_q, gcnt_d;
  logic [15:0] dst_q, dst_d;
  logic [63:0] ts_q, tsw_q, tsw_d, word;
  logic        stop_q, stop_d, in_pkt;
  logic [7:0]  ctrl;
  // a stop seen in HDR suppresses W0 so no partial packet ever leaves
  always_comb begin
    in_pkt = !reset && (state_q == HDR || state_q == PAYLOAD);
    busy = state_q != IDLE;
    probes_sent = sent_q;
    out_wr = !reset && out_rdy && (state_q == PAYLOAD || (state_q == HDR && !stop));
    word = idx_q == 4'd0 ? {dst_q, 16'd8, 16'd0, 16'd64} :
           idx_q == 4'd1 ? {32'h52545450, sent_q} :
           idx_q == 4'd2 ? tsw_q : 64'd0;
    ctrl = idx_q == 4'd0 ? 8'hFF : idx_q == 4'd8 ? 8'h01 : 8'h00;
    out_data = in_pkt ? DATA_WIDTH'(word) : '0;
    out_ctrl = in_pkt ? CTRL_WIDTH'(ctrl) : '0;
  end
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    sent_d = sent_q;
    num_d = num_q;
    gap_d = gap_q;
    gcnt_d = gcnt_q;
    dst_d = dst_q;
    tsw_d = tsw_q;
    stop_d = stop_q;
    case (state_q)
      IDLE: if (start && num_probes != 32'd0) begin
        state_d = HDR;
        idx_d = 4'd0;
        sent_d = 32'd0;
        num_d = num_probes;
        gap_d = gap_cycles;
        dst_d = dst_port;
        stop_d = 1'b0;
      end
      HDR: if (stop) state_d = IDLE;
        else if (out_wr) begin
          state_d = PAYLOAD;
          idx_d = 4'd1;
          tsw_d = ts_q;
        end
      PAYLOAD: begin
        stop_d = stop_q || stop;
        if (out_wr && idx_q == 4'd8) begin
          idx_d = 4'd0;
          sent_d = sent_q + 32'd1;
          gcnt_d = gap_q;
          stop_d = 1'b0;
          state_d = (sent_q + 32'd1 == num_q || stop_q || stop) ? IDLE :
                    gap_q == 32'd0 ? HDR : GAP;
        end else if (out_wr) idx_d = idx_q + 4'd1;
      end
      default: begin
        state_d = (stop || stop_q) ? IDLE : gcnt_q <= 32'd1 ? HDR : GAP;
        gcnt_d = gcnt_q - 32'd1;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q <= 4'd0;
      sent_q <= 32'd0;
      num_q <= 32'd0;
      gap_q <= 32'd0;
      gcnt_q <= 32'd0;
      dst_q <= 16'd0;
      ts_q <= 64'd0;
      tsw_q <= 64'd0;
      stop_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      sent_q <= sent_d;
      num_q <= num_d;
      gap_q <= gap_d;
      gcnt_q <= gcnt_d;
      dst_q <= dst_d;
      ts_q <= ts_q + 64'd1;
      tsw_q <= tsw_d;
      stop_q <= stop_d;
    end
  end
endmodule
